// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates NUM_CH requesters (ch0 = instruction fetch, ch1 = load/store)
//   onto one memory port with a single outstanding transaction.
//   FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : round-robin arbitration. The search starts
//                                   at pointer p, and p becomes winner+1 on
//                                   every grant.
//                       undefined : fixed priority, where the lowest index
//                                   wins.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   ch_req/ch_addr/ch_we/ch_wdata/ch_be
//                                    per-channel request; channel i is at
//                                    slice i
//   ch_gnt                           one-hot grant pulse (combinational, IDLE only)
//   ch_rvalid, ch_rdata              one-hot completion pulse + shared read data
//   mem_req/mem_addr/mem_we/mem_wdata/mem_be, mem_ready
//                                    memory request channel
//   mem_rvalid, mem_rdata            memory completion (reads and writes)
module mem_port_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH*BE_W-1:0]   ch_be,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [BE_W-1:0]          mem_be,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state_q, state_d;

  // Flat channel buses viewed as per-channel packed arrays.
  logic [NUM_CH-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_CH-1:0][DATA_W-1:0] wdata_a;
  logic [NUM_CH-1:0][BE_W-1:0]   be_a;
  assign addr_a  = ch_addr;
  assign wdata_a = ch_wdata;
  assign be_a    = ch_be;

  req_t             req_q, req_w;
  logic [IDX_W-1:0] owner_q, win_idx;
  logic             grant, complete;

  // ---------------- arbitration ----------------
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    int   c;
    logic found;
    c       = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!found && ch_req[c]) begin
        found   = 1'b1;
        win_idx = IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr_q <= '0;
    else if (grant) ptr_q <= (int'(win_idx) == NUM_CH - 1) ? '0 : win_idx + 1'b1;
  end
`else
  // Walk from the top down so the lowest set index is the one that sticks.
  always_comb begin
    win_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (ch_req[k]) win_idx = IDX_W'(k);
  end
`endif

  always_comb begin
    req_w.addr  = addr_a[win_idx];
    req_w.we    = ch_we[win_idx];
    req_w.wdata = wdata_a[win_idx];
    req_w.be    = be_a[win_idx];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A same-cycle mem_ready+mem_rvalid in ISSUE is the zero-wait memory case:
  // it completes straight away and skips WAIT. A mem_rvalid without
  // mem_ready in ISSUE is ignored.
  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    complete = 1'b0;
    mem_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        grant = rst_n && (|ch_req);
        if (grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          complete = mem_rvalid;
          state_d  = mem_rvalid ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        complete = mem_rvalid;
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_gnt = '0;
    if (grant) ch_gnt[win_idx] = 1'b1;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      owner_q   <= '0;
      ch_rvalid <= '0;
      ch_rdata  <= '0;
    end else begin
      ch_rvalid <= '0;
      if (grant) begin
        req_q   <= req_w;
        owner_q <= win_idx;
      end
      if (complete) begin
        ch_rvalid[owner_q] <= 1'b1;
        ch_rdata           <= mem_rdata;
      end
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_we    = req_q.we;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;

endmodule
